// File: rtl/async_event_arbiter.sv
// rtl/async_event_arbiter.sv - synchronizes asynchronous event lines and serves them round-robin over valid/ready
module async_event_arbiter #(
  parameter  int NUM_REQ     = 4,
  parameter  int SYNC_STAGES = 2,
  localparam int IDW         = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] async_req,
  output logic               evt_valid,
  output logic [IDW-1:0]     evt_id,
  input  logic               evt_ready,
  output logic [NUM_REQ-1:0] pending,
  output logic [NUM_REQ-1:0] overrun,
  input  logic               overrun_clr
);

  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("async_event_arbiter: SYNC_STAGES must be at least 2");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("async_event_arbiter: NUM_REQ must be in 2..16");
  end

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_OFFER = 1'b1;

  logic [NUM_REQ-1:0]   r_sync [SYNC_STAGES];
  logic [NUM_REQ-1:0]   r_hist;
  logic [NUM_REQ-1:0]   r_pending;
  logic [NUM_REQ-1:0]   r_overrun;
  logic [0:0]           r_state;
  logic                 r_valid;
  logic [IDW-1:0]       r_id;
  logic [IDW-1:0]       r_ptr;

  logic [NUM_REQ-1:0]   w_sync;
  logic [NUM_REQ-1:0]   w_rise;
  logic                 w_hs;
  logic [NUM_REQ-1:0]   w_clr;
  logic [NUM_REQ-1:0]   w_ovr_set;
  logic [2*NUM_REQ-1:0] w_rot;
  logic [IDW:0]         w_sum;
  logic                 w_found;
  logic [IDW-1:0]       w_sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= async_req;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= w_sync;
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_rise = w_sync & ~r_hist;

  // A new edge landing on the cycle its line is being acknowledged is a fresh event, not an overrun.
  assign w_hs      = r_valid & evt_ready;
  assign w_clr     = w_hs ? (NUM_REQ'(1) << r_id) : '0;
  assign w_ovr_set = w_rise & r_pending & ~w_clr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_rise;
      r_overrun <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;
    end
  end

  // Rotate so bit 0 is the pointer position; the lowest set bit is the next winner.
  assign w_rot = {r_pending, r_pending} >> r_ptr;

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    w_sel   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_ptr} + (IDW+1)'(k);
      end
    end
    if (w_sum >= (IDW+1)'(NUM_REQ)) w_sel = IDW'(w_sum - (IDW+1)'(NUM_REQ));
    else                            w_sel = w_sum[IDW-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_id    <= w_sel;
            r_valid <= 1'b1;
            r_state <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (evt_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + IDW'(1);
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign evt_valid = r_valid;
  assign evt_id    = r_id;
  assign pending   = r_pending;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_async_event_arbiter.sv
// tb/tb_async_event_arbiter.sv - scoreboard bench for async_event_arbiter
module tb_async_event_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] async_req;
  logic         evt_valid;
  logic [1:0]   evt_id;
  logic         evt_ready;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         overrun_clr;

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  logic       hold = 1'b0;
  logic [1:0] hold_id = '0;

  always #5 clk = ~clk;

  async_event_arbiter #(.NUM_REQ(N), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .async_req  (async_req),
    .evt_valid  (evt_valid),
    .evt_id     (evt_id),
    .evt_ready  (evt_ready),
    .pending    (pending),
    .overrun    (overrun),
    .overrun_clr(overrun_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name, input int maxc);
    int c = 0;
    while (exp_q.size() != 0 && c < maxc) begin
      tick();
      c++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  task automatic wait_valid(input string name, input int maxc);
    int c = 0;
    while (!evt_valid && c < maxc) begin
      tick();
      c++;
    end
    chk(name, evt_valid, 1);
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    async_req   = '0;
    evt_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick();
  endtask

  // Monitor: pops the scoreboard on every handshake and checks offers stay put under backpressure.
  always @(negedge clk) begin
    if (!reset_n) begin
      hold = 1'b0;
    end else begin
      if (hold) chk("hold_stable", {29'd0, evt_valid, evt_id}, {29'd0, 1'b1, hold_id});
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_evt: got id %0d expected none", evt_id);
        end else begin
          chk("evt_id", evt_id, exp_q.pop_front());
        end
      end
      hold    = evt_valid && !evt_ready;
      hold_id = evt_id;
    end
  end

  initial begin
    do_reset();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overrun", overrun, 0);

    // Latency: valid appears exactly after the fourth edge following the rise.
    async_req = 4'b0001;
    tick(3);
    chk("lat_pending_e3", pending, 4'b0001);
    chk("lat_valid_e3", evt_valid, 0);
    async_req = 4'b0000;
    tick();
    chk("lat_valid_e4", evt_valid, 1);
    chk("lat_id_e4", evt_id, 0);
    exp_q.push_back(0);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("lat_valid_after", evt_valid, 0);
    chk("lat_pending_after", pending, 0);

    // Round-robin from a fresh pointer.
    do_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    evt_ready = 1'b1;
    async_req = 4'b1111;
    tick(3);
    async_req = 4'b0000;
    wait_drain("rr_all_drain", 30);
    tick(2);
    exp_q.push_back(0); exp_q.push_back(2);
    async_req = 4'b0101;
    tick(3);
    async_req = 4'b0000;
    wait_drain("rr_02_drain", 30);
    tick(2);
    exp_q.push_back(0); exp_q.push_back(2);
    async_req = 4'b0101;
    tick(3);
    async_req = 4'b0000;
    wait_drain("rr_wrap_drain", 30);
    tick(2);
    evt_ready = 1'b0;

    // Backpressure with a competing line arriving during the stall.
    exp_q.push_back(1);
    async_req = 4'b0010;
    tick(3);
    async_req = 4'b0000;
    wait_valid("bp_offer", 10);
    chk("bp_first_id", evt_id, 1);
    async_req = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_held", evt_valid, 1);
      chk("bp_id_held", evt_id, 1);
    end
    async_req = 4'b0000;
    exp_q.push_back(0);
    evt_ready = 1'b1;
    tick();
    chk("bp_bubble", evt_valid, 0);
    tick();
    chk("bp_next_valid", evt_valid, 1);
    chk("bp_next_id", evt_id, 0);
    tick();
    evt_ready = 1'b0;
    chk("bp_drain", exp_q.size(), 0);

    // Overrun on line 2.
    async_req = 4'b0100;
    tick(3);
    async_req = 4'b0000;
    wait_valid("ov_offer", 10);
    chk("ov_id", evt_id, 2);
    tick(2);
    async_req = 4'b0100;
    tick(3);
    async_req = 4'b0000;
    chk("ov_set", overrun, 4'b0100);
    chk("ov_pending", pending, 4'b0100);
    exp_q.push_back(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("ov_pending_clr", pending, 0);
    tick(3);
    chk("ov_single_evt", evt_valid, 0);
    chk("ov_sticky", overrun, 4'b0100);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ov_cleared", overrun, 0);

    // Clear coinciding with a fresh overrun: set must win.
    async_req = 4'b0100;
    tick(3);
    async_req = 4'b0000;
    wait_valid("ov2_offer", 10);
    tick(2);
    async_req = 4'b0100;
    tick(2);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    async_req = 4'b0000;
    chk("ov_clr_vs_set", overrun, 4'b0100);
    exp_q.push_back(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    chk("ov2_cleared", overrun, 0);

    // Collision: new edge on line 3 on the same edge as its handshake.
    async_req = 4'b1000;
    tick(3);
    async_req = 4'b0000;
    wait_valid("col_offer", 10);
    chk("col_id", evt_id, 3);
    tick(2);
    async_req = 4'b1000;
    tick(2);
    exp_q.push_back(3);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    async_req = 4'b0000;
    chk("col_pending", pending, 4'b1000);
    chk("col_no_overrun", overrun, 0);
    exp_q.push_back(3);
    evt_ready = 1'b1;
    wait_drain("col_second", 10);
    tick();
    evt_ready = 1'b0;

    // Reset while offering line 2.
    async_req = 4'b0100;
    tick(3);
    async_req = 4'b0000;
    wait_valid("rmo_offer", 10);
    chk("rmo_id", evt_id, 2);
    #3;
    reset_n = 1'b0;
    #1;
    chk("rmo_valid_drop", evt_valid, 0);
    chk("rmo_pending_drop", pending, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(10);
    chk("rmo_no_spurious", evt_valid, 0);
    chk("rmo_pending_quiet", pending, 0);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
